// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared segment types, blank code and hex segment table for the display scanner
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK    = 7'h7F;
    localparam int   BLANK_CYCLES = 2;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam seg_t SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_segments.sv
// rtl/hex_to_segments.sv - combinational 4-bit to active-low 7-segment decoder
module hex_to_segments
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       segments
);

    assign segments = SEG_CODES[nibble];

endmodule

// File: rtl/register_display_scanner.sv
// rtl/register_display_scanner.sv - multiplexed 7-segment scanner with per-frame snapshot; optional LEADING_ZERO_BLANK_EN
module register_display_scanner
    import display_pkg::*;
#(
    parameter int REGISTER_WIDTH = 16,
    parameter int CLOCK_DIVIDE   = 50000
) (
    input  logic                        clock,
    input  logic                        isResetN,
    input  logic [REGISTER_WIDTH-1:0]   register1Value,
    input  logic                        displayEnable,
    output logic [6:0]                  segments,
    output logic [REGISTER_WIDTH/4-1:0] digitSelect,
    output logic                        frameDone
);

    localparam int DIGIT_COUNT = REGISTER_WIDTH / 4;
    localparam int PRESC_W     = $clog2(CLOCK_DIVIDE);
    localparam int DIGIT_W     = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;

    logic [PRESC_W-1:0]        prescaler;
    logic [DIGIT_W-1:0]        digit_index;
    logic [REGISTER_WIDTH-1:0] snapshot;
    logic                      load_pending;

    logic       tick;
    logic       frame_wrap;
    logic       show;
    logic       lead_zero;
    logic [3:0] nibble;
    seg_t       decoded;

    assign tick       = (prescaler == PRESC_W'(CLOCK_DIVIDE - 1));
    assign frame_wrap = tick && (digit_index == DIGIT_W'(DIGIT_COUNT - 1));
    assign show       = (prescaler >= PRESC_W'(BLANK_CYCLES));
    assign nibble     = 4'(snapshot >> {digit_index, 2'b00});

`ifdef LEADING_ZERO_BLANK_EN
    // Blank digit k>0 when it and every more-significant nibble are zero
    assign lead_zero = (digit_index != '0) && ((snapshot >> {digit_index, 2'b00}) == '0);
`else
    assign lead_zero = 1'b0;
`endif

    hex_to_segments u_hex_to_segments (
        .nibble   (nibble),
        .segments (decoded)
    );

    always_ff @(posedge clock or negedge isResetN) begin
        if (!isResetN) begin
            prescaler    <= '0;
            digit_index  <= '0;
            snapshot     <= '0;
            load_pending <= 1'b1;
        end else begin
            load_pending <= 1'b0;
            if (!displayEnable) begin
                prescaler   <= '0;
                digit_index <= '0;
                snapshot    <= register1Value;
            end else begin
                if (tick) begin
                    prescaler   <= '0;
                    digit_index <= frame_wrap ? '0 : digit_index + DIGIT_W'(1);
                end else begin
                    prescaler <= prescaler + PRESC_W'(1);
                end
                if (load_pending || frame_wrap) begin
                    snapshot <= register1Value;
                end
            end
        end
    end

    // Outputs lag the scan state by one clock; blanking covers the slot change
    always_ff @(posedge clock or negedge isResetN) begin
        if (!isResetN) begin
            segments    <= SEG_BLANK;
            digitSelect <= '1;
            frameDone   <= 1'b0;
        end else if (!displayEnable) begin
            segments    <= SEG_BLANK;
            digitSelect <= '1;
            frameDone   <= 1'b0;
        end else begin
            frameDone <= frame_wrap;
            if (show && !lead_zero) begin
                segments    <= decoded;
                digitSelect <= ~(DIGIT_COUNT'(1) << digit_index);
            end else begin
                segments    <= SEG_BLANK;
                digitSelect <= '1;
            end
        end
    end

endmodule

// File: tb/tb_register_display_scanner.sv
// tb/tb_register_display_scanner.sv - randomized scoreboard bench for register_display_scanner
module tb_register_display_scanner;

    localparam int CD = 4;
    localparam int RW = 16;
    localparam int DC = RW / 4;
    localparam int FRAME = CD * DC;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] sel;
        logic       fd;
    } exp_t;

    logic          clock = 1'b0;
    logic          rst_n;
    logic [RW-1:0] val;
    logic          en;
    logic [6:0]    segments;
    logic [DC-1:0] digit_select;
    logic          frame_done;

    register_display_scanner #(.REGISTER_WIDTH(RW), .CLOCK_DIVIDE(CD)) dut (
        .clock          (clock),
        .isResetN       (rst_n),
        .register1Value (val),
        .displayEnable  (en),
        .segments       (segments),
        .digitSelect    (digit_select),
        .frameDone      (frame_done)
    );

    always #5 clock = ~clock;

    logic [6:0] hex_tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    exp_t          q[$];
    int            checks = 0;
    int            passes = 0;
    int            t = 0;
    bit            first = 1'b1;
    logic [RW-1:0] snap = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h expected=%h (time %0t)", name, act, exp, $time);
    endtask

    // Reference: scan position is t cycles since the scan (re)started
    task automatic model_push();
        exp_t e;
        int p, d, upper;
        logic [3:0] one;
        one = 4'b0001;
        e.seg = 7'h7F; e.sel = 4'hF; e.fd = 1'b0;
        if (!rst_n) begin
            t = 0; first = 1'b1; snap = '0;
        end else if (!en) begin
            snap = val; t = 0; first = 1'b0;
        end else begin
            p = t % CD;
            d = (t / CD) % DC;
            upper = int'(snap) >> (4 * d);
            if (p >= 2 && !(LZB && d > 0 && upper == 0)) begin
                e.sel = ~(one << d);
                e.seg = hex_tbl[upper & 15];
            end
            e.fd = ((t % FRAME) == FRAME - 1);
            if (first || e.fd) snap = val;
            first = 1'b0;
            t++;
        end
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        model_push();
        #1;
    endtask

    task automatic async_reset();
        @(negedge clock);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_seg", 32'(segments), 32'h7F);
        check("async_rst_sel", 32'(digit_select), 32'hF);
        check("async_rst_fd", 32'(frame_done), 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            check("one_hot_low", 32'($countones(~digit_select) <= 1), 32'h1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("segments", 32'(segments), 32'(e.seg));
                check("digit_select", 32'(digit_select), 32'(e.sel));
                check("frame_done", 32'(frame_done), 32'(e.fd));
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0; en = 1'b1; val = 16'h1234;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (6) step();
        val = 16'hABCD;
        repeat (40) step();
        repeat (5) step();
        en = 1'b0;
        repeat (10) step();
        en = 1'b1;
        repeat (30) step();
        for (int i = 0; i < 40 && (t % FRAME) != 9; i++) step();
        async_reset();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) step();
        val = 16'h0005;
        repeat (40) step();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: val = 16'($urandom_range(15));
                    1: val = 16'($urandom_range(255));
                    default: val = 16'($urandom);
                endcase
            end
            if (en) en = ($urandom_range(99) != 0);
            else    en = ($urandom_range(5) == 0);
            if ($urandom_range(299) == 0) begin
                async_reset();
                step();
                rst_n = 1'b1;
            end
            step();
        end
        repeat (2) @(negedge clock);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain actual=%0d expected=0 pending", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
